cmd_queue_ctrl: RTL and testbench

Command-and-control block for the follower robot. It generalises the single-destination go/stop controller to a queue of up to DEPTH destinations, adds a configurable dwell pause at each intermediate stop, and parametrises ID width and buzzer period. It sits between the UART command receiver (cmd/cmd_rdy), the barcode reader (ID/ID_vld) and the motion/buzzer logic (go, buzz/buzz_n).

---
 rtl/cmd_queue_ctrl_pkg.sv | 30 +++
 rtl/cmd_queue_ctrl_if.sv | 40 ++++
 rtl/cmd_queue_ctrl_dest_fifo.sv | 80 ++++++++
 rtl/cmd_queue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cmd_queue_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cmd_queue_ctrl_pkg.sv
// Shared types for the follower-robot command queue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: command opcodes, controller states, parameter defaults and a
// width helper that never returns zero.
package cmd_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_STOP   = 2'b00,
      OP_GO     = 2'b01,
      OP_APPEND = 2'b10,
      OP_RSVD   = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRANSIT = 2'd1,
      DWELL   = 2'd2
   } state_t;

   localparam int BUZZ_PERIOD_DEF = 12500;
   localparam int DWELL_CYC_DEF   = 50000;

   // Counter width able to hold 0..n-1; at least one bit so n == 1 still works.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmd_queue_ctrl_if.sv
// Bundles the UART command, barcode and motion/buzzer signals of the controller.
// Latency: n/a (wiring only).
// Backpressure: cmd_rdy / ID_vld are held by their sources until clr_cmd_rdy / clr_ID_vld.
//
// slave  : controller side (takes cmd, cmd_rdy, ID, ID_vld, OK2Move; drives the rest)
// master : environment side (UART receiver, barcode reader, motion logic)
interface cmd_queue_ctrl_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [7:0]       cmd;
   logic             cmd_rdy;
   logic [7:0]       ID;
   logic             ID_vld;
   logic             OK2Move;
   logic             go;
   logic             in_transit;
   logic             clr_cmd_rdy;
   logic             clr_ID_vld;
   logic             buzz;
   logic             buzz_n;
   logic             arrived;
   logic             cmd_drop;
   logic [CNT_W-1:0] q_cnt;
   logic             q_full;

   modport slave (
      input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
      output go, in_transit, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n,
             arrived, cmd_drop, q_cnt, q_full
   );

   modport master (
      output cmd, cmd_rdy, ID, ID_vld, OK2Move,
      input  go, in_transit, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n,
             arrived, cmd_drop, q_cnt, q_full
   );

endinterface

// File: rtl/cmd_queue_ctrl_dest_fifo.sv
// Circular queue of destination IDs; head is the current navigation target.
// Latency: updates visible one cycle after the operation; head/count are registered.
// Backpressure: push ignored when full, pop ignored when empty; caller checks o_full.
//
// Ports: clk, rst (sync, active-high); i_flush empties the queue; i_load empties it
// and writes i_dat as the only entry; i_push appends i_dat; i_pop drops the head;
// o_head, o_cnt, o_full report the queue. Priority: rst/flush > load > push/pop.
module dest_fifo #(
   parameter int ID_W  = 6,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_load,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [ID_W-1:0]              i_dat,
   output logic [ID_W-1:0]              o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
   output logic                         o_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [ID_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_cnt;

   logic            w_full;
   logic            w_do_push;
   logic            w_do_pop;
   logic            w_we;
   logic [PW-1:0]   w_waddr;

   assign w_full    = (r_cnt == CW'(DEPTH));
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & (r_cnt != '0);

   // A load restarts the ring at slot 0 so the single entry is the head.
   assign w_we    = ~rst & ~i_flush & (i_load | w_do_push);
   assign w_waddr = i_load ? '0 : r_wr_ptr;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= i_dat;
      end
   end

   // Pointers are PW bits wide, so the +1 wraps modulo DEPTH (a power of 2).
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else if (i_load) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= PW'(1);
         r_cnt    <= CW'(1);
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head = r_mem[r_rd_ptr];
   assign o_cnt  = r_cnt;
   assign o_full = w_full;

endmodule

// File: rtl/cmd_queue_ctrl.sv
// Follower-robot command controller: queue of destinations, dwell at intermediate stops, obstacle buzzer.
// Latency: acks/arrived/cmd_drop combinational in the presenting cycle; state, q_cnt, buzz one cycle later.
// Backpressure: a command is consumed every cycle cmd_rdy is high; ID waits while a command is present.
//
// Ports: clk, rst (sync, active-high); bus (slave modport) carries cmd/cmd_rdy from
// the UART, ID/ID_vld from the barcode reader, OK2Move from the obstacle check, and
// drives go, in_transit, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n, arrived, cmd_drop,
// q_cnt and q_full.
module cmd_queue_ctrl
   import cmd_ctrl_pkg::*;
#(
   parameter int ID_W        = 6,
   parameter int DEPTH       = 4,
   parameter int DWELL_CYC   = DWELL_CYC_DEF,
   parameter int BUZZ_PERIOD = BUZZ_PERIOD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   cmd_queue_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DW_W  = cnt_w(DWELL_CYC);
   localparam int BZ_W  = cnt_w(BUZZ_PERIOD);

   localparam logic [DW_W-1:0] DWELL_LD = DW_W'(DWELL_CYC - 1);
   localparam logic [BZ_W-1:0] BZ_LAST  = BZ_W'(BUZZ_PERIOD - 1);
   localparam logic [BZ_W-1:0] BZ_HALF  = BZ_W'(BUZZ_PERIOD / 2);

   state_t           r_state;
   state_t           w_state_nxt;
   opcode_t          w_op;

   logic             w_cmd_v;
   logic             w_id_v;
   logic             w_id_hit;
   logic [ID_W-1:0]  w_head;
   logic [CNT_W-1:0] w_cnt;
   logic             w_full;

   logic             w_flush;
   logic             w_load;
   logic             w_push;
   logic             w_pop;
   logic             w_arrived;
   logic             w_cmd_drop;
   logic             w_dwell_ld;

   logic [DW_W-1:0]  r_dwell_cnt;
   logic [BZ_W-1:0]  r_buzz_cnt;
   logic             r_buzz;
   logic             r_buzz_n;
   logic             w_in_transit;
   logic             w_buzz_en;
   logic             w_buzz_hi;

   // Upper ID/cmd bits beyond ID_W are intentionally ignored.
   logic             w_unused_ok;
   assign w_unused_ok = ^{bus.cmd, bus.ID};

   assign w_op    = opcode_t'(bus.cmd[7:6]);
   assign w_cmd_v = bus.cmd_rdy;
   // A pending command blocks the ID for this cycle so the ID is compared
   // against the head the command leaves behind.
   assign w_id_v  = bus.ID_vld & ~bus.cmd_rdy;
   // Count guard keeps a stale slot from matching when the queue is empty.
   assign w_id_hit = (bus.ID[ID_W-1:0] == w_head) && (w_cnt != '0);

   dest_fifo #(
      .ID_W  (ID_W),
      .DEPTH (DEPTH)
   ) u_dest_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_load  (w_load),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_dat   (bus.cmd[ID_W-1:0]),
      .o_head  (w_head),
      .o_cnt   (w_cnt),
      .o_full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ID/dwell handling first, then the command path overrides it; w_id_v is
   // low whenever a command is present, so pop and push never coincide.
   always_comb begin
      w_state_nxt = r_state;
      w_flush     = 1'b0;
      w_load      = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_arrived   = 1'b0;
      w_cmd_drop  = 1'b0;
      w_dwell_ld  = 1'b0;

      case (r_state)
         TRANSIT: begin
            if (w_id_v && w_id_hit) begin
               w_pop     = 1'b1;
               w_arrived = 1'b1;
               if (w_cnt == CNT_W'(1)) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DWELL;
                  w_dwell_ld  = 1'b1;
               end
            end
         end
         DWELL: begin
            if (r_dwell_cnt == '0) begin
               w_state_nxt = TRANSIT;
            end
         end
         default: ;
      endcase

      if (w_cmd_v) begin
         case (w_op)
            OP_STOP: begin
               w_flush     = 1'b1;
               w_state_nxt = IDLE;
            end
            OP_GO: begin
               w_load      = 1'b1;
               w_state_nxt = TRANSIT;
            end
            OP_APPEND: begin
               if (w_full) begin
                  w_cmd_drop = 1'b1;
               end else begin
                  w_push = 1'b1;
                  if (r_state == IDLE) begin
                     w_state_nxt = TRANSIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Loaded with DWELL_CYC-1 on entry and exits on zero: DWELL_CYC cycles in DWELL.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dwell_cnt <= '0;
      end else if (w_dwell_ld) begin
         r_dwell_cnt <= DWELL_LD;
      end else if ((r_state == DWELL) && (r_dwell_cnt != '0)) begin
         r_dwell_cnt <= r_dwell_cnt - DW_W'(1);
      end
   end

   assign w_in_transit = (r_state == TRANSIT);
   assign w_buzz_en    = w_in_transit & ~bus.OK2Move;
   assign w_buzz_hi    = (r_buzz_cnt >= BZ_HALF);

   // Both buzzer drives are registered so they drop together one cycle after
   // the enable falls, and are never both high.
   always_ff @(posedge clk) begin
      if (rst || !w_buzz_en) begin
         r_buzz_cnt <= '0;
         r_buzz     <= 1'b0;
         r_buzz_n   <= 1'b0;
      end else begin
         r_buzz_cnt <= (r_buzz_cnt == BZ_LAST) ? '0 : r_buzz_cnt + BZ_W'(1);
         r_buzz     <= w_buzz_hi;
         r_buzz_n   <= ~w_buzz_hi;
      end
   end

   assign bus.in_transit  = w_in_transit;
   assign bus.go          = w_in_transit & bus.OK2Move;
   assign bus.clr_cmd_rdy = w_cmd_v;
   assign bus.clr_ID_vld  = w_id_v;
   assign bus.arrived     = w_arrived;
   assign bus.cmd_drop    = w_cmd_drop;
   assign bus.q_cnt       = w_cnt;
   assign bus.q_full      = w_full;
   assign bus.buzz        = r_buzz;
   assign bus.buzz_n      = r_buzz_n;

endmodule

// File: tb/tb_cmd_queue_ctrl.sv
// Self-checking bench for cmd_queue_ctrl (DEPTH=4, DWELL_CYC=3, BUZZ_PERIOD=8).
// Stimulus pushes expected handshakes and per-cycle status into queues;
// the negedge monitor pops and compares them against the DUT outputs.
module tb_cmd_queue_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cmd_queue_ctrl_if #(.DEPTH(4)) bus ();

   cmd_queue_ctrl #(
      .ID_W        (6),
      .DEPTH       (4),
      .DWELL_CYC   (3),
      .BUZZ_PERIOD (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       it;
      logic       go;
      logic [2:0] cnt;
      logic       full;
      logic       bz;
      logic       bzn;
   } st_t;

   // ack bits: {clr_cmd_rdy, clr_ID_vld, arrived, cmd_drop}
   logic [3:0] ack_q [$];
   st_t        st_q  [$];

   int   n_tests = 0;
   int   n_fail  = 0;
   logic done    = 1'b0;

   logic [3:0] m_ack;
   logic [3:0] m_ack_exp;
   st_t        m_st;
   st_t        m_st_exp;

   always @(negedge clk) begin
      m_ack = {bus.clr_cmd_rdy, bus.clr_ID_vld, bus.arrived, bus.cmd_drop};
      if (m_ack != 4'b0000) begin
         n_tests++;
         if (ack_q.size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected t=%0t got=%b required=none", $time, m_ack);
         end else begin
            m_ack_exp = ack_q.pop_front();
            if (m_ack !== m_ack_exp) begin
               n_fail++;
               $display("FAIL ack t=%0t got=%b required=%b", $time, m_ack, m_ack_exp);
            end
         end
      end
      if (st_q.size() != 0) begin
         m_st_exp = st_q.pop_front();
         m_st = '{it: bus.in_transit, go: bus.go, cnt: bus.q_cnt, full: bus.q_full,
                  bz: bus.buzz, bzn: bus.buzz_n};
         n_tests++;
         if (m_st !== m_st_exp) begin
            n_fail++;
            $display("FAIL status t=%0t got it/go/cnt/full/bz/bzn=%b/%b/%0d/%b/%b/%b required=%b/%b/%0d/%b/%b/%b",
                     $time, m_st.it, m_st.go, m_st.cnt, m_st.full, m_st.bz, m_st.bzn,
                     m_st_exp.it, m_st_exp.go, m_st_exp.cnt, m_st_exp.full, m_st_exp.bz, m_st_exp.bzn);
         end
      end
      if (done) begin
         n_tests++;
         if (ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL ack_leftover got=%0d pending required=0", ack_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   // One clock cycle of stimulus plus the outputs expected during that cycle.
   task automatic cyc(input logic [7:0] c, input logic cr, input logic [7:0] id,
                      input logic iv, input logic ok, input logic [3:0] ack,
                      input logic it, input logic [2:0] cnt, input logic bz, input logic bzn);
      bus.cmd     = c;
      bus.cmd_rdy = cr;
      bus.ID      = id;
      bus.ID_vld  = iv;
      bus.OK2Move = ok;
      if (ack != 4'b0000) ack_q.push_back(ack);
      st_q.push_back('{it: it, go: it & ok, cnt: cnt, full: (cnt == 3'd4), bz: bz, bzn: bzn});
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input logic it, input logic [2:0] cnt);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, it, cnt, 1'b0, 1'b0);
   endtask

   task automatic cmd_in(input logic [7:0] c, input logic it, input logic [2:0] cnt, input logic drop);
      cyc(c, 1'b1, 8'h00, 1'b0, 1'b1, {1'b1, 2'b00, drop}, it, cnt, 1'b0, 1'b0);
   endtask

   task automatic id_in(input logic [7:0] id, input logic it, input logic [2:0] cnt, input logic arr);
      cyc(8'h00, 1'b0, id, 1'b1, 1'b1, {1'b0, 1'b1, arr, 1'b0}, it, cnt, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      bus.cmd     = 8'h00;
      bus.cmd_rdy = 1'b0;
      bus.ID      = 8'h00;
      bus.ID_vld  = 1'b0;
      bus.OK2Move = 1'b1;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic bz_e;

   initial begin
      rst = 1'b1;
      do_reset();
      do_reset();

      // Reset state
      nop(1'b0, 3'd0);

      // Single destination: GO 5, wrong ID 3, then ID 5
      cmd_in(8'h45, 1'b0, 3'd0, 1'b0);
      nop(1'b1, 3'd1);
      id_in(8'h03, 1'b1, 3'd1, 1'b0);
      id_in(8'h05, 1'b1, 3'd1, 1'b1);
      nop(1'b0, 3'd0);

      // Queue and dwell: GO 1, APPEND 2, APPEND 3
      cmd_in(8'h41, 1'b0, 3'd0, 1'b0);
      cmd_in(8'h82, 1'b1, 3'd1, 1'b0);
      cmd_in(8'h83, 1'b1, 3'd2, 1'b0);
      id_in(8'h01, 1'b1, 3'd3, 1'b1);
      nop(1'b0, 3'd2);
      nop(1'b0, 3'd2);
      nop(1'b0, 3'd2);
      nop(1'b1, 3'd2);
      id_in(8'h02, 1'b1, 3'd2, 1'b1);
      nop(1'b0, 3'd1);
      nop(1'b0, 3'd1);
      nop(1'b0, 3'd1);
      id_in(8'h03, 1'b1, 3'd1, 1'b1);
      nop(1'b0, 3'd0);

      // Overflow: fill to 4, APPEND 5 dropped, STOP flushes
      cmd_in(8'h41, 1'b0, 3'd0, 1'b0);
      cmd_in(8'h82, 1'b1, 3'd1, 1'b0);
      cmd_in(8'h83, 1'b1, 3'd2, 1'b0);
      cmd_in(8'h84, 1'b1, 3'd3, 1'b0);
      cmd_in(8'h85, 1'b1, 3'd4, 1'b1);
      nop(1'b1, 3'd4);
      cmd_in(8'h00, 1'b1, 3'd4, 1'b0);
      nop(1'b0, 3'd0);

      // Command and ID together: head 7, GO 9 with ID 7
      cmd_in(8'h47, 1'b0, 3'd0, 1'b0);
      cyc(8'h49, 1'b1, 8'h07, 1'b1, 1'b1, 4'b1000, 1'b1, 3'd1, 1'b0, 1'b0);
      id_in(8'h07, 1'b1, 3'd1, 1'b0);
      id_in(8'h09, 1'b1, 3'd1, 1'b1);
      nop(1'b0, 3'd0);

      // APPEND from IDLE starts transit; STOP returns to IDLE
      cmd_in(8'h84, 1'b0, 3'd0, 1'b0);
      nop(1'b1, 3'd1);
      cmd_in(8'h00, 1'b1, 3'd1, 1'b0);
      nop(1'b0, 3'd0);

      // Buzzer: blocked path in TRANSIT, 4 low / 4 high, then path clears
      cmd_in(8'h42, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 22; k++) begin
         bz_e = (k != 0) && (((k - 1) % 8) >= 4);
         cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd1, bz_e, (k != 0) && !bz_e);
      end
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd1, 1'b1, 1'b0);
      id_in(8'h02, 1'b1, 3'd1, 1'b1);
      nop(1'b0, 3'd0);

      // Reset mid-DWELL with two entries left, then a reserved command
      cmd_in(8'h41, 1'b0, 3'd0, 1'b0);
      cmd_in(8'h82, 1'b1, 3'd1, 1'b0);
      cmd_in(8'h83, 1'b1, 3'd2, 1'b0);
      id_in(8'h01, 1'b1, 3'd3, 1'b1);
      nop(1'b0, 3'd2);
      do_reset();
      nop(1'b0, 3'd0);
      cmd_in(8'hC0, 1'b0, 3'd0, 1'b0);
      nop(1'b0, 3'd0);
      nop(1'b0, 3'd0);

      done = 1'b1;
   end

endmodule
